// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture path: FSM states and default frame geometry
// used by the divider, the sample reader and the EEPROM logger.
package adc_pkg;

  localparam int unsigned DEF_DATA_BITS = 12;
  localparam int unsigned DEF_NULL_BITS = 2;
  localparam int unsigned DEF_CS_IDLE   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_NULLB,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a slow strobe already in the clk domain; rise is a
// single-clk pulse on the first cycle the input is seen high.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic r_in_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_in_d <= 1'b0;
    else     r_in_d <= in;
  end

  assign rise = in & ~r_in_d;

endmodule

// File: rtl/adc_sample_reader.sv
// Serial ADC frame reader: drives CS_n, shifts DOUT MSB-first on adcclock rises and
// hands completed words to the logger through a valid/ready holding register.
module adc_sample_reader
  import adc_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned NULL_BITS = DEF_NULL_BITS,
  parameter int unsigned CS_IDLE   = DEF_CS_IDLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adcclock,
  input  logic                 enable,
  input  logic                 adc_dout,
  output logic                 adc_cs_n,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned    CW        = $clog2(max3(DATA_BITS, NULL_BITS, CS_IDLE) + 1);
  localparam logic [CW-1:0]  LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0]  LAST_NULL = CW'(NULL_BITS - 1);
  localparam logic [CW-1:0]  LAST_IDLE = CW'(CS_IDLE - 1);

  state_t                 r_state;
  logic                   r_cs_n;
  logic [CW-1:0]          r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shreg;
  logic                   r_complete;
  logic [DATA_BITS-1:0]   r_sample;
  logic                   r_valid;
  logic                   r_overrun;
  logic                   w_rise;

  edge_pulse u_adcclk_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (adcclock),
    .rise (w_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cs_n     <= 1'b1;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_complete <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      if (w_rise) begin
        case (r_state)
          S_IDLE: begin
            if (enable) begin
              r_state   <= S_SELECT;
              r_cs_n    <= 1'b0;
              r_bit_cnt <= '0;
            end
          end
          S_SELECT: begin
            r_bit_cnt <= '0;
            r_state   <= (NULL_BITS > 0) ? S_NULLB : S_SHIFT;
          end
          S_NULLB: begin
            if (r_bit_cnt == LAST_NULL) begin
              r_state   <= S_SHIFT;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_SHIFT: begin
            r_shreg <= {r_shreg[DATA_BITS-2:0], adc_dout};
            if (r_bit_cnt == LAST_DATA) begin
              // complete fires next clk, when r_shreg already holds the LSB
              r_state    <= S_DONE;
              r_cs_n     <= 1'b1;
              r_bit_cnt  <= '0;
              r_complete <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (r_bit_cnt == LAST_IDLE) begin
              r_bit_cnt <= '0;
              if (enable) begin
                r_state <= S_SELECT;
                r_cs_n  <= 1'b0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_cs_n    <= 1'b1;
            r_bit_cnt <= '0;
          end
        endcase
      end
    end
  end

  // A consume on the same edge as a completion frees the slot for the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_complete) begin
      if (!r_valid || sample_ready) begin
        r_sample <= r_shreg;
        r_valid  <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && sample_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign adc_cs_n     = r_cs_n;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;
  assign busy         = (r_state != S_IDLE);

endmodule
